// File: rtl/blink_sequencer_pkg.sv
// Shared types and parameter defaults for the LED blink sequencer.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int COUNT_LENGTH_DEF = 3;
  localparam int BLINK_W_DEF      = 4;

endpackage

// File: rtl/blink_sequencer_phase_timer.sv
// Loadable down-counter; o_tc marks the last cycle of a programmed interval.
import blink_pkg::*;

module phase_timer #(
  parameter int COUNT_LENGTH = COUNT_LENGTH_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [COUNT_LENGTH-1:0] i_val,
  output logic                    o_tc
);

  logic [COUNT_LENGTH-1:0] count_q, count_d;

  assign o_tc = (count_q == COUNT_LENGTH'(1)) && !i_load;

  // On the terminal count the timer reloads from i_val, which the owner points
  // at the next phase's duration, so back-to-back phases have no gap cycle.
  always_comb begin
    count_d = count_q;
    if (i_load || o_tc)
      count_d = i_val;
    else if (count_q != '0)
      count_d = count_q - COUNT_LENGTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/blink_sequencer.sv
// Runs N on/off LED blink cycles with programmable on/off durations.
import blink_pkg::*;

module blink_sequencer #(
  parameter int COUNT_LENGTH = COUNT_LENGTH_DEF,
  parameter int BLINK_W      = BLINK_W_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [COUNT_LENGTH-1:0] i_on_time,
  input  logic [COUNT_LENGTH-1:0] i_off_time,
  input  logic [BLINK_W-1:0]      i_blinks,
  input  logic                    i_abort,
  output logic                    o_led,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BLINK_W-1:0]      o_blink_cnt
);

  state_e                  state_q, state_d;
  logic [COUNT_LENGTH-1:0] on_q, on_d;
  logic [COUNT_LENGTH-1:0] off_q, off_d;
  logic [BLINK_W-1:0]      blinks_q, blinks_d;
  logic [BLINK_W-1:0]      cnt_q, cnt_d;

  logic                    tmr_load;
  logic [COUNT_LENGTH-1:0] tmr_val;
  logic                    tmr_tc;
  logic [COUNT_LENGTH-1:0] on_eff, off_eff, on_in_eff;

  // Zero durations behave as one cycle.
  assign on_eff    = (on_q  == '0) ? COUNT_LENGTH'(1) : on_q;
  assign off_eff   = (off_q == '0) ? COUNT_LENGTH'(1) : off_q;
  assign on_in_eff = (i_on_time == '0) ? COUNT_LENGTH'(1) : i_on_time;

  phase_timer #(.COUNT_LENGTH(COUNT_LENGTH)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (tmr_load),
    .i_val   (tmr_val),
    .o_tc    (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    on_d     = on_q;
    off_d    = off_q;
    blinks_d = blinks_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_val  = on_eff;
    unique case (state_q)
      IDLE: begin
        tmr_val = on_in_eff;
        if (i_start) begin
          on_d     = i_on_time;
          off_d    = i_off_time;
          blinks_d = i_blinks;
          cnt_d    = '0;
          tmr_load = 1'b1;
          state_d  = (i_blinks == '0) ? DONE : ON;
        end
      end
      ON: begin
        tmr_val = off_eff;
        if (i_abort) begin
          state_d = IDLE;
        end else if (tmr_tc) begin
          state_d = OFF;
          cnt_d   = cnt_q + BLINK_W'(1);
        end
      end
      OFF: begin
        tmr_val = on_eff;
        if (i_abort)
          state_d = IDLE;
        else if (tmr_tc)
          state_d = (cnt_q == blinks_q) ? DONE : ON;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      on_q     <= '0;
      off_q    <= '0;
      blinks_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      on_q     <= on_d;
      off_q    <= off_d;
      blinks_q <= blinks_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_led       = (state_q == ON);
  assign o_busy      = (state_q == ON) || (state_q == OFF);
  assign o_done      = (state_q == DONE);
  assign o_blink_cnt = cnt_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed checks of blink_sequencer timing, counts, abort and reset behaviour.
module tb_blink_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [2:0] on_t, off_t;
  logic [3:0] blinks;
  logic       led, busy, done;
  logic [3:0] bcnt;

  int n_checks = 0;
  int n_errors = 0;

  blink_sequencer #(.COUNT_LENGTH(3), .BLINK_W(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_on_time   (on_t),
    .i_off_time  (off_t),
    .i_blinks    (blinks),
    .i_abort     (abort),
    .o_led       (led),
    .o_busy      (busy),
    .o_done      (done),
    .o_blink_cnt (bcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && !done; i++) step();
    chk(tag, done, 1);
  endtask

  task automatic kick(input int on_v, input int off_v, input int n_v);
    on_t   = 3'(on_v);
    off_t  = 3'(off_v);
    blinks = 4'(n_v);
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  int nom_led [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
  int nom_cnt [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 2, 2};
  int ign_led [6]  = '{1, 1, 0, 1, 1, 0};
  int on_len;

  initial begin
    rst_n = 1'b0; start = 1'b1; abort = 1'b0;
    on_t = 3'd1; off_t = 3'd1; blinks = 4'd1;

    // Reset held with start high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_led", led, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", bcnt, 0);
    end
    rst_n = 1'b1;
    step();
    chk("rel_led", led, 1);
    chk("rel_busy", busy, 1);
    start = 1'b0;
    wait_done("rel_done", 20);
    chk("rel_cnt", bcnt, 1);
    step();

    // Nominal on=3 off=2 N=2
    kick(3, 2, 2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("nom_led%0d", i + 1), led, nom_led[i]);
      chk($sformatf("nom_cnt%0d", i + 1), bcnt, nom_cnt[i]);
      chk($sformatf("nom_busy%0d", i + 1), busy, 1);
      chk($sformatf("nom_ndone%0d", i + 1), done, 0);
      step();
    end
    chk("nom_done", done, 1);
    chk("nom_done_led", led, 0);
    chk("nom_cnt_end", bcnt, 2);
    step();
    chk("nom_done_pulse", done, 0);
    chk("nom_idle_busy", busy, 0);

    // Zero durations: one-cycle phases
    kick(0, 0, 3);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("zero_led%0d", i + 1), led, (i % 2 == 0) ? 1 : 0);
      step();
    end
    chk("zero_done", done, 1);
    chk("zero_cnt", bcnt, 3);
    step();

    // Zero blinks: immediate done, no LED
    kick(2, 2, 0);
    chk("n0_done", done, 1);
    chk("n0_led", led, 0);
    chk("n0_busy", busy, 0);
    chk("n0_cnt", bcnt, 0);
    step();
    chk("n0_done_pulse", done, 0);

    // Abort in OFF of blink 1
    kick(5, 5, 4);
    for (int i = 0; i < 6; i++) step();
    chk("ab_c7_led", led, 0);
    chk("ab_c7_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_led", led, 0);
    chk("ab_cnt", bcnt, 1);
    for (int i = 0; i < 3; i++) step();
    chk("ab_no_done", done, 0);
    chk("ab_cnt_hold", bcnt, 1);

    // Start and abort together in IDLE: start wins
    abort = 1'b1;
    kick(1, 1, 1);
    abort = 1'b0;
    chk("col_led", led, 1);
    chk("col_busy", busy, 1);
    step(); step();
    chk("col_done", done, 1);
    step();

    // Start held high through a run while on_time changes
    on_t = 3'd2; off_t = 3'd1; blinks = 4'd2; start = 1'b1;
    step();
    on_t = 3'd5;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ign_led%0d", i + 1), led, ign_led[i]);
      step();
    end
    chk("ign_done", done, 1);
    step();
    chk("ign_idle_busy", busy, 0);
    chk("ign_idle_done", done, 0);
    step();
    chk("restart_led", led, 1);
    chk("restart_cnt", bcnt, 0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("restart_on5_last", led, 1);
    step();
    chk("restart_on5_off", led, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("restart_abort_busy", busy, 0);

    // Maximum on duration
    kick(7, 1, 1);
    on_len = 0;
    for (int i = 0; i < 20 && led; i++) begin
      on_len++;
      step();
    end
    chk("max_on_len", on_len, 7);
    wait_done("max_done", 10);
    step();

    // Reset mid-ON of blink 2
    kick(2, 1, 3);
    step(); step(); step();
    chk("mrst_pre_led", led, 1);
    chk("mrst_pre_cnt", bcnt, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_led", led, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", bcnt, 0);
    step();
    chk("mrst_idle", busy, 0);
    chk("mrst_no_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
